seq_alu: RTL

- Multi-cycle ALU execute stage. Sits directly downstream of the ALU control decoder and consumes its 4-bit alu_control code plus two register/immediate operands.
- Logic, add/sub and compare ops complete in one cycle. Shifts are iterative, one bit position per cycle.
- Start/ready/done handshake lets the core stall during long shifts.

---
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multi-cycle ALU execute stage. Logic, add/sub and compare ops
//             finish in one cycle. Shifts move one bit position per cycle,
//             and a start/ready/done handshake covers the variable latency.
//  Ports    : clk, rst_n (async, active low)
//             start, alu_control[3:0], op_a, op_b   - request
//             ready (IDLE only), done (1-cycle pulse) - handshake
//             result, zero, err                      - registered outputs
//  Config   : define SEQ_ALU_FAST_SHIFT_EN to replace the iterative shifter
//             with a single-cycle barrel shifter. Results are identical.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SUB  = 4'b0011;
  localparam logic [3:0] c_OP_XOR  = 4'b0100;
  localparam logic [3:0] c_OP_SLL  = 4'b0101;
  localparam logic [3:0] c_OP_SRL  = 4'b0110;
  localparam logic [3:0] c_OP_SRA  = 4'b0111;
  localparam logic [3:0] c_OP_SLT  = 4'b1000;
  localparam logic [3:0] c_OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic [WIDTH-1:0] w_res;
  logic             w_illegal;
  logic             w_long_shift;
  logic             w_accept;
  logic [SHW-1:0]   w_shamt;

  assign w_shamt  = op_b[SHW-1:0];
  assign w_accept = start && (r_state == S_IDLE);

  // Single-cycle datapath. In the iterative build a shift only lands here
  // when its amount is zero, so the result is simply op_a.
  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (alu_control)
      c_OP_AND:  w_res = op_a & op_b;
      c_OP_OR:   w_res = op_a | op_b;
      c_OP_ADD:  w_res = op_a + op_b;
      c_OP_SUB:  w_res = op_a - op_b;
      c_OP_XOR:  w_res = op_a ^ op_b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      c_OP_SLL:  w_res = op_a << w_shamt;
      c_OP_SRL:  w_res = op_a >> w_shamt;
      c_OP_SRA:  w_res = WIDTH'($signed(op_a) >>> w_shamt);
`else
      c_OP_SLL,
      c_OP_SRL,
      c_OP_SRA:  w_res = op_a;
`endif
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default:   w_illegal = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_FAST_SHIFT_EN
  assign w_long_shift = 1'b0;
`else
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_kind;   // alu_control[1:0]: 01 SLL, 10 SRL, 11 SRA
  logic [WIDTH-1:0] w_step;

  assign w_long_shift = (alu_control == c_OP_SLL || alu_control == c_OP_SRL ||
                         alu_control == c_OP_SRA) && (w_shamt != '0);

  always_comb begin
    w_step = r_acc;
    case (r_kind)
      2'b01:   w_step = {r_acc[WIDTH-2:0], 1'b0};
      2'b10:   w_step = {1'b0, r_acc[WIDTH-1:1]};
      2'b11:   w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_step = r_acc;
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_long_shift ? S_SHIFT : S_DONE;
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        if (r_cnt == SHW'(1)) w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers: result/zero/err change only when a result is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      r_acc    <= '0;
      r_cnt    <= '0;
      r_kind   <= 2'b00;
`endif
    end else if (w_accept) begin
      if (!w_long_shift) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_err    <= w_illegal;
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      r_acc  <= op_a;
      r_cnt  <= w_shamt;
      r_kind <= alu_control[1:0];
`endif
    end
`ifndef SEQ_ALU_FAST_SHIFT_EN
    else if (r_state == S_SHIFT) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) begin
        r_result <= w_step;
        r_zero   <= (w_step == '0);
        r_err    <= 1'b0;
      end
    end
`endif
  end

  assign ready  = (r_state == S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign zero   = r_zero;
  assign err    = r_err;

endmodule

`default_nettype wire
